// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extends the selected load lane and splices
// sub-word store data into a fetched word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] storeData,
  output logic [31:0] loadValue,
  output logic [31:0] mergedWord
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    loadValue = {{24{lane_b[7]}}, lane_b};
      F3_H:    loadValue = {{16{lane_h[15]}}, lane_h};
      F3_BU:   loadValue = {24'h000000, lane_b};
      F3_HU:   loadValue = {16'h0000, lane_h};
      default: loadValue = word;
    endcase

    mergedWord = word;
    case (funct3)
      F3_B: mergedWord[{offset, 3'b000} +: 8] = storeData[7:0];
      F3_H: begin
        if (offset[1]) mergedWord[31:16] = storeData[15:0];
        else           mergedWord[15:0]  = storeData[15:0];
      end
      default: mergedWord = storeData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates byte-addressed requests and sequences
// word-wide memory accesses, with read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRSIZE  = 32,
  parameter int WORDSIZE  = 32,
  parameter int WADDRBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [2:0]           funct3,
  input  logic [31:0]          address,
  input  logic [WORDSIZE-1:0]  storeData,
  output logic [WORDSIZE-1:0]  loadData,
  output logic                 done,
  output logic                 error,
  output logic                 busy,
  output logic                 dmemRead,
  output logic                 dmemWrite,
  output logic [WADDRBITS-1:0] dmemAddress,
  output logic [WORDSIZE-1:0]  dmemWriteData,
  input  logic [WORDSIZE-1:0]  dmemReadData
);

  lsu_state_t state, state_next;

  logic [2:0]           funct3_q;
  logic [WADDRBITS+1:0] addr_q;
  logic [WORDSIZE-1:0]  store_q;
  logic                 is_store_q;
  logic                 error_q;
  logic                 req_err;
  logic [31:0]          align_load;
  logic [31:0]          align_merge;

  lsu_lane_align u_align (
    .word      (dmemReadData),
    .offset    (addr_q[1:0]),
    .funct3    (funct3_q),
    .storeData (store_q),
    .loadValue (align_load),
    .mergedWord(align_merge)
  );

  // Request validation against live inputs; only consulted when accepting in IDLE.
  always_comb begin
    req_err = 1'b0;
    if (memRead == memWrite)
      req_err = 1'b1;
    else if (memRead && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
      req_err = 1'b1;
    else if (memWrite && (funct3 > F3_W))
      req_err = 1'b1;
    if (funct3[1:0] == 2'd2 && address[1:0] != 2'b00)
      req_err = 1'b1;
    if (funct3[1:0] == 2'd1 && address[0])
      req_err = 1'b1;
    if ({2'b00, address[31:2]} >= 32'(ADDRSIZE))
      req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_err)                          state_next = DONE;
          else if (memWrite && funct3 == F3_W)  state_next = WR;
          else                                  state_next = RD;
        end
      end
      RD:      state_next = MERGE;
      MERGE:   state_next = DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are gated by reset so an in-flight access is dropped in the reset cycle itself.
  always_comb begin
    dmemRead      = 1'b0;
    dmemWrite     = 1'b0;
    dmemWriteData = store_q;
    case (state)
      RD: dmemRead = !reset;
      MERGE: begin
        if (is_store_q) begin
          dmemWrite     = !reset;
          dmemWriteData = align_merge;
        end
      end
      WR:      dmemWrite = !reset;
      default: ;
    endcase
  end

  assign dmemAddress = addr_q[WADDRBITS+1:2];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign error       = done && error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      store_q    <= '0;
      is_store_q <= 1'b0;
      error_q    <= 1'b0;
      loadData   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        funct3_q   <= funct3;
        addr_q     <= address[WADDRBITS+1:0];
        store_q    <= storeData;
        is_store_q <= memWrite;
        error_q    <= req_err;
      end
      if (state == MERGE && !is_store_q)
        loadData <= align_load;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        done;
  logic        error;
  logic        busy;
  logic        dmemRead;
  logic        dmemWrite;
  logic [4:0]  dmemAddress;
  logic [31:0] dmemWriteData;
  logic [31:0] dmemReadData;

  load_store_unit #(.ADDRSIZE(32), .WORDSIZE(32), .WADDRBITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .funct3       (funct3),
    .address      (address),
    .storeData    (storeData),
    .loadData     (loadData),
    .done         (done),
    .error        (error),
    .busy         (busy),
    .dmemRead     (dmemRead),
    .dmemWrite    (dmemWrite),
    .dmemAddress  (dmemAddress),
    .dmemWriteData(dmemWriteData),
    .dmemReadData (dmemReadData)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];

  always @(posedge clk) begin
    if (dmemWrite) mem[dmemAddress] <= dmemWriteData;
    if (dmemRead)  dmemReadData     <= mem[dmemAddress];
  end

  int          n_rd = 0;
  int          n_wr = 0;
  int          n_done = 0;
  logic [31:0] last_wd = '0;
  logic [4:0]  last_wa = '0;

  always @(negedge clk) begin
    if (dmemRead) n_rd <= n_rd + 1;
    if (dmemWrite) begin
      n_wr    <= n_wr + 1;
      last_wd <= dmemWriteData;
      last_wa <= dmemAddress;
    end
    if (done) n_done <= n_done + 1;
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        exp_err;
    logic [31:0] exp_load;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wd;
    int          exp_wa;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string nm, logic rd, logic wr, int f3, logic [31:0] a,
                              logic [31:0] sd, logic err, logic [31:0] ld, int lat,
                              int nr, int nw, logic [31:0] wd, int wa);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = 3'(f3); v.addr = a; v.sdata = sd;
    v.exp_err = err; v.exp_load = ld; v.exp_lat = lat; v.exp_rd = nr; v.exp_wr = nw;
    v.exp_wd = wd; v.exp_wa = wa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   r0, w0, lat;
    bit   seen;
    @(negedge clk);
    req = 1'b1; memRead = v.rd; memWrite = v.wr; funct3 = v.f3;
    address = v.addr; storeData = v.sdata;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    req = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    r0 = n_rd; w0 = n_wr; seen = 1'b0; lat = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", e.name, lat);
    end else begin
      chk({e.name, " latency"}, 32'(lat), 32'(e.exp_lat));
      chk({e.name, " error"}, {31'b0, error}, {31'b0, e.exp_err});
      chk({e.name, " loadData"}, loadData, e.exp_load);
      chk({e.name, " reads"}, 32'(n_rd - r0), 32'(e.exp_rd));
      chk({e.name, " writes"}, 32'(n_wr - w0), 32'(e.exp_wr));
      if (e.exp_wr > 0) begin
        chk({e.name, " wdata"}, last_wd, e.exp_wd);
        chk({e.name, " waddr"}, {27'b0, last_wa}, 32'(e.exp_wa));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, w0;
    vec_t v;

    vecs.push_back(mk("sw_8",     0, 1, 2, 32'h08, 32'hDEADBEEF, 0, 32'h00000000, 2, 0, 1, 32'hDEADBEEF, 2));
    vecs.push_back(mk("lb_9",     1, 0, 0, 32'h09, 32'h0,        0, 32'hFFFFFFBE, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("lbu_9",    1, 0, 4, 32'h09, 32'h0,        0, 32'h000000BE, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("lh_a",     1, 0, 1, 32'h0A, 32'h0,        0, 32'hFFFFDEAD, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("lw_8",     1, 0, 2, 32'h08, 32'h0,        0, 32'hDEADBEEF, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("sb_b",     0, 1, 0, 32'h0B, 32'h00000012, 0, 32'hDEADBEEF, 3, 1, 1, 32'h12ADBEEF, 2));
    vecs.push_back(mk("lw_8b",    1, 0, 2, 32'h08, 32'h0,        0, 32'h12ADBEEF, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("lw_mis6",  1, 0, 2, 32'h06, 32'h0,        1, 32'h12ADBEEF, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("sh_mis5",  0, 1, 1, 32'h05, 32'hFFFF,     1, 32'h12ADBEEF, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("ld_f3_3",  1, 0, 3, 32'h08, 32'h0,        1, 32'h12ADBEEF, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("lw_oor",   1, 0, 2, 32'h80, 32'h0,        1, 32'h12ADBEEF, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("sh_2",     0, 1, 1, 32'h02, 32'hCAFE1234, 0, 32'h12ADBEEF, 3, 1, 1, 32'h12340000, 0));
    vecs.push_back(mk("lhu_2",    1, 0, 5, 32'h02, 32'h0,        0, 32'h00001234, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("both_rw",  1, 1, 2, 32'h00, 32'h0,        1, 32'h00001234, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("st_f3_3",  0, 1, 3, 32'h00, 32'h0,        1, 32'h00001234, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("sw_7c",    0, 1, 2, 32'h7C, 32'h00000080, 0, 32'h00001234, 2, 0, 1, 32'h00000080, 31));
    vecs.push_back(mk("lb_7c",    1, 0, 0, 32'h7C, 32'h0,        0, 32'hFFFFFF80, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("lhu_7c",   1, 0, 5, 32'h7C, 32'h0,        0, 32'h00000080, 3, 1, 0, 32'h0, 0));
    vecs.push_back(mk("no_type",  0, 0, 2, 32'h00, 32'h0,        1, 32'h00000080, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("lbu_b",    1, 0, 4, 32'h0B, 32'h0,        0, 32'h00000012, 3, 1, 0, 32'h0, 0));

    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b1; req = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    funct3 = '0; address = '0; storeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst error", {31'b0, error}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst loadData", loadData, 32'd0);
    chk("rst dmemRead", {31'b0, dmemRead}, 32'd0);
    chk("rst dmemWrite", {31'b0, dmemWrite}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // req raised while in RD and in DONE must be ignored
    d0 = n_done; r0 = n_rd; w0 = n_wr;
    @(negedge clk);
    req = 1'b1; memRead = 1'b1; funct3 = 3'd2; address = 32'h08;
    @(posedge clk);
    #1;
    req = 1'b0; memRead = 1'b0;
    @(negedge clk);
    chk("ign in RD busy", {31'b0, busy}, 32'd1);
    req = 1'b1; memWrite = 1'b1; funct3 = 3'd2; address = 32'h00; storeData = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign done pulse", {31'b0, done}, 32'd1);
    req = 1'b1; memWrite = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; memWrite = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("ign done count", 32'(n_done - d0), 32'd1);
    chk("ign reads", 32'(n_rd - r0), 32'd1);
    chk("ign writes", 32'(n_wr - w0), 32'd0);
    chk("ign loadData", loadData, 32'h12ADBEEF);
    chk("ign busy idle", {31'b0, busy}, 32'd0);

    // reset during MERGE of an SB abandons the write and the done pulse
    @(negedge clk);
    req = 1'b1; memWrite = 1'b1; funct3 = 3'd0; address = 32'h00; storeData = 32'h00000055;
    @(posedge clk);
    #1;
    req = 1'b0; memWrite = 1'b0;
    d0 = n_done; w0 = n_wr;
    @(negedge clk);
    chk("rstm RD read", {31'b0, dmemRead}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rstm no write", {31'b0, dmemWrite}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstm busy", {31'b0, busy}, 32'd0);
    chk("rstm done", {31'b0, done}, 32'd0);
    chk("rstm loadData", loadData, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    chk("rstm done count", 32'(n_done - d0), 32'd0);
    chk("rstm write count", 32'(n_wr - w0), 32'd0);
    chk("rstm mem0", mem[0], 32'h12340000);

    v = mk("lw_0_after_rst", 1, 0, 2, 32'h00, 32'h0, 0, 32'h12340000, 3, 1, 0, 32'h0, 0);
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between core datapath/control and the word-addressed data memory: converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses.
- Does sign/zero extension on loads, and read-modify-write for sub-word stores.
- Rejects misaligned or invalid accesses.
- Core stalls on busy and consumes loadData on done.

Parameters:
- ADDRSIZE, 32, number of memory words.
- WORDSIZE, 32, memory word width; fixed at 32 for RV32.
- WADDRBITS, 5, word-index width, equal to log2(ADDRSIZE).

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  request strobe, sampled only in IDLE.
- memRead  in  1  load request type.
- memWrite  in  1  store request type.
- funct3  in  3  RV32I width/sign code.
- address  in  32  byte address.
- storeData  in  32  store source, low lanes used for SB/SH.
- loadData  out  32  extended load result, registered.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; access rejected.
- busy  out  1  high whenever state != IDLE.
- dmemRead  out  1  to data memory memRead.
- dmemWrite  out  1  to data memory memWrite.
- dmemAddress  out  WADDRBITS  word index, equal to address[WADDRBITS+1:2].
- dmemWriteData  out  32  full word to memory.
- dmemReadData  in  32  memory readData; registered inside memory, valid the cycle after dmemRead.

Behaviour:
- Reset: synchronous, active-high.
  - state=IDLE, loadData=0, done=0, error=0, captured request regs=0.
  - dmemRead/dmemWrite forced 0 in any cycle where reset=1, including mid-operation. An in-flight access is abandoned with no done.
- States: IDLE, RD, MERGE, WR, DONE.
  - dmem strobes, address and write data are combinational from state and the captured request only, never from live inputs.
- IDLE, req=1: capture funct3, address, storeData and type.
  - Error if any of:
    - memRead and memWrite both high, or both low;
    - invalid funct3: loads {3,6,7}, stores >2;
    - misaligned: word access with address[1:0]!=0, or half access with address[0]!=0;
    - address[31:WADDRBITS+2] != 0.
  - On error: go to DONE with error latched.
  - Else: load or SB/SH goes to RD; SW goes to WR.
  - req while busy is ignored.
- RD: dmemRead=1 → MERGE.
- MERGE: dmemReadData valid.
  - Load: lane select by address[1:0] (little-endian), LB/LH sign-extend, LBU/LHU zero-extend, register into loadData → DONE.
  - Sub-word store: dmemWrite=1, dmemWriteData = read word with lane replaced (SB: byte address[1:0] ← storeData[7:0]; SH: half address[1] ← storeData[15:0]) → DONE.
- WR: dmemWrite=1, dmemWriteData=storeData → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
  - error is valid only while done=1 and is 0 otherwise.
  - A new req is accepted only from the following IDLE cycle.
- Latency in cycles, accept-to-done: loads 3, SB/SH 3, SW 2, error 1.
- loadData holds its last value until the next successful load; stores and errors leave it unchanged.
- Memory is never accessed for a rejected request: zero dmemRead/dmemWrite cycles.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5) and the state enum.
- One combinational sub-module lsu_lane_align:
  - inputs: word, byte offset, funct3, storeData;
  - outputs: extended load value and merged store word.
- Top holds the FSM and capture registers.

Test Plan:
- Reset, then SW address=0x8 data=0xDEADBEEF → WR asserts dmemWrite, dmemAddress=2, dmemWriteData=0xDEADBEEF; done 2 cycles after accept, error=0.
- With word 2=0xDEADBEEF:
  - LB address=0x9 → loadData=0xFFFFFFBE;
  - LBU address=0x9 → 0x000000BE;
  - LH address=0xA → 0xFFFFDEAD;
  - LW address=0x8 → 0xDEADBEEF.
  - Each completes 3 cycles after accept with one dmemRead cycle.
- SB address=0xB data=0x12 onto 0xDEADBEEF → RD then MERGE writes 0x12ADBEEF; a following LW address=0x8 returns 0x12ADBEEF.
- Rejected requests (no dmem strobes, done+error next cycle, loadData unchanged):
  - LW address=0x6;
  - SH address=0x5;
  - funct3=3 load;
  - address=0x80.
- req asserted in RD and in DONE → ignored, exactly one done.
- reset asserted in MERGE during SB → no dmemWrite that cycle, state IDLE, done never pulses, busy=0 next cycle.
